// File: rtl/ex_mem_latch.sv
// ex_mem_latch
// EX/MEM pipeline register plus the architectural Z/V/N flag register.
// Sits directly after the ALU compute stage: registers the ALU address,
// result and EX control bits for the memory stage, commits flags with an
// opcode-dependent write mask, resolves branch conditions from the
// committed flags, and latches a sticky halt once HLT is captured.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               hold every register this cycle (wins over flush)
//   flush               turn the incoming EX instruction into a bubble
//   ex_valid            EX slot holds a real instruction
//   ex_opcode[3:0]      EX opcode (4'b1111 = HLT)
//   ex_addr[15:0]       ALU memory address
//   ex_result[15:0]     ALU result / store data
//   ex_flag[2:0]        raw ALU flags {N, V, Z}
//   ex_rd[3:0]          destination register
//   ex_reg_write, ex_mem_read, ex_mem_write   EX control bits
//   br_cond[2:0]        branch condition code from decode
//   mem_*               registered copies for the memory stage
//   flags[2:0]          committed flags {N, V, Z}
//   br_taken            combinational branch decision from flags
//   halted              sticky halt, cleared only by rst
module ex_mem_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_result,
  input  logic [2:0]  ex_flag,
  input  logic [3:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  br_cond,
  output logic        mem_valid,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_halt,
  output logic [3:0]  mem_opcode,
  output logic [3:0]  mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_result,
  output logic [2:0]  flags,
  output logic        br_taken,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Branch resolution on committed flags {N, V, Z}.
  function automatic logic branch_eval(input logic [2:0] f, input logic [2:0] cond);
    logic z, v, n;
    z = f[0];
    v = f[1];
    n = f[2];
    case (cond)
      3'b000:  branch_eval = !z;
      3'b001:  branch_eval = z;
      3'b010:  branch_eval = !z && !n;
      3'b011:  branch_eval = n;
      3'b100:  branch_eval = z || (!z && !n);
      3'b101:  branch_eval = n || z;
      3'b110:  branch_eval = v;
      default: branch_eval = 1'b1;
    endcase
  endfunction

  logic        mem_valid_q,     mem_valid_d;
  logic        mem_reg_write_q, mem_reg_write_d;
  logic        mem_mem_read_q,  mem_mem_read_d;
  logic        mem_mem_write_q, mem_mem_write_d;
  logic        mem_halt_q,      mem_halt_d;
  logic [3:0]  mem_opcode_q,    mem_opcode_d;
  logic [3:0]  mem_rd_q,        mem_rd_d;
  logic [15:0] mem_addr_q,      mem_addr_d;
  logic [15:0] mem_result_q,    mem_result_d;
  logic [2:0]  flags_q,         flags_d;
  logic        halted_q,        halted_d;
  logic        cap;

  // A real, unflushed instruction while not halted; stall is handled by
  // simply not loading the registers at all.
  assign cap = !stall && !flush && ex_valid && !halted_q;

  always_comb begin
    // Default: hold everything (covers stall).
    mem_valid_d     = mem_valid_q;
    mem_reg_write_d = mem_reg_write_q;
    mem_mem_read_d  = mem_mem_read_q;
    mem_mem_write_d = mem_mem_write_q;
    mem_halt_d      = mem_halt_q;
    mem_opcode_d    = mem_opcode_q;
    mem_rd_d        = mem_rd_q;
    mem_addr_d      = mem_addr_q;
    mem_result_d    = mem_result_q;
    flags_d         = flags_q;
    halted_d        = halted_q;

    if (!stall) begin
      if (cap) begin
        mem_valid_d     = 1'b1;
        mem_reg_write_d = ex_reg_write;
        mem_mem_read_d  = ex_mem_read;
        mem_mem_write_d = ex_mem_write;
        mem_halt_d      = (ex_opcode == OP_HLT);
        mem_opcode_d    = ex_opcode;
        mem_rd_d        = ex_rd;
        mem_addr_d      = ex_addr;
        mem_result_d    = ex_result;
        if (ex_opcode == OP_HLT) halted_d = 1'b1;

        // ADD/SUB commit all three flags; logic/shift ops commit Z only.
        case (ex_opcode)
          OP_ADD, OP_SUB:                 flags_d    = ex_flag;
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[0] = ex_flag[0];
          default:                        flags_d    = flags_q;
        endcase
      end else begin
        // Bubble: data fields are zeroed too, not just the valid bit.
        mem_valid_d     = 1'b0;
        mem_reg_write_d = 1'b0;
        mem_mem_read_d  = 1'b0;
        mem_mem_write_d = 1'b0;
        mem_halt_d      = 1'b0;
        mem_opcode_d    = 4'd0;
        mem_rd_d        = 4'd0;
        mem_addr_d      = 16'd0;
        mem_result_d    = 16'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_halt_q      <= 1'b0;
      mem_opcode_q    <= 4'd0;
      mem_rd_q        <= 4'd0;
      mem_addr_q      <= 16'd0;
      mem_result_q    <= 16'd0;
      flags_q         <= 3'b000;
      halted_q        <= 1'b0;
    end else begin
      mem_valid_q     <= mem_valid_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      mem_mem_write_q <= mem_mem_write_d;
      mem_halt_q      <= mem_halt_d;
      mem_opcode_q    <= mem_opcode_d;
      mem_rd_q        <= mem_rd_d;
      mem_addr_q      <= mem_addr_d;
      mem_result_q    <= mem_result_d;
      flags_q         <= flags_d;
      halted_q        <= halted_d;
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_reg_write = mem_reg_write_q;
  assign mem_mem_read  = mem_mem_read_q;
  assign mem_mem_write = mem_mem_write_q;
  assign mem_halt      = mem_halt_q;
  assign mem_opcode    = mem_opcode_q;
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign mem_result    = mem_result_q;
  assign flags         = flags_q;
  assign halted        = halted_q;
  assign br_taken      = branch_eval(flags_q, br_cond);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed testbench for ex_mem_latch with hand-computed expectations.
module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, ex_valid;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_addr, ex_result;
  logic [2:0]  ex_flag, br_cond;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
  logic [3:0]  mem_opcode, mem_rd;
  logic [15:0] mem_addr, mem_result;
  logic [2:0]  flags;
  logic        br_taken, halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_addr(ex_addr), .ex_result(ex_result),
    .ex_flag(ex_flag), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .br_cond(br_cond),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_halt(mem_halt), .mem_opcode(mem_opcode), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_result(mem_result), .flags(flags),
    .br_taken(br_taken), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] r, input logic [2:0] f);
    ex_valid  = v;
    ex_opcode = op;
    ex_addr   = a;
    ex_result = r;
    ex_flag   = f;
  endtask

  // Reference branch table, flags as {N,V,Z}.
  function automatic logic ref_br(input logic [2:0] f, input logic [2:0] c);
    case (c)
      3'd0: return f[0] == 1'b0;
      3'd1: return f[0] == 1'b1;
      3'd2: return f[0] == 1'b0 && f[2] == 1'b0;
      3'd3: return f[2] == 1'b1;
      3'd4: return f[0] == 1'b1 || (f[0] == 1'b0 && f[2] == 1'b0);
      3'd5: return f[2] == 1'b1 || f[0] == 1'b1;
      3'd6: return f[1] == 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_cond = 3'b000;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid", mem_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_halted", halted, 0);
    chk("rst_br_ne", br_taken, 1);
    br_cond = 3'b001; #1;
    chk("rst_br_eq", br_taken, 0);
    rst = 1'b0;

    // ADD capture
    drive(1'b1, 4'b0000, 16'h1234, 16'h0000, 3'b011);
    ex_rd = 4'd5; ex_reg_write = 1'b1;
    step();
    chk("add_result", mem_result, 16'h0000);
    chk("add_addr", mem_addr, 16'h1234);
    chk("add_valid", mem_valid, 1);
    chk("add_rd", mem_rd, 5);
    chk("add_regwr", mem_reg_write, 1);
    chk("add_flags", flags, 3'b011);
    chk("add_br_eq", br_taken, 1);

    // SUB then XOR (Z only) then PADDSB (no write)
    ex_reg_write = 1'b0; ex_mem_write = 1'b1;
    drive(1'b1, 4'b0001, 16'h0010, 16'hBEEF, 3'b110);
    step();
    chk("sub_flags", flags, 3'b110);
    chk("sub_memwr", mem_mem_write, 1);
    ex_mem_write = 1'b0;
    drive(1'b1, 4'b0011, 16'h0020, 16'h0F0F, 3'b001);
    step();
    chk("xor_flags", flags, 3'b111);
    drive(1'b1, 4'b0111, 16'h0030, 16'hA5A5, 3'b000);
    step();
    chk("paddsb_flags", flags, 3'b111);
    chk("paddsb_op", mem_opcode, 4'b0111);
    chk("paddsb_res", mem_result, 16'hA5A5);

    // Stall 3 cycles, flush also in cycle 2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      drive(1'b1, 4'b0000, 16'h4000 + 16'(i), 16'h1111 * 16'(i + 1), 3'(i));
      step();
      chk("stall_res", mem_result, 16'hA5A5);
      chk("stall_addr", mem_addr, 16'h0030);
      chk("stall_valid", mem_valid, 1);
      chk("stall_flags", flags, 3'b111);
    end
    stall = 1'b0; flush = 1'b1;
    drive(1'b1, 4'b0000, 16'h5555, 16'h6666, 3'b000);
    step();
    chk("flush_valid", mem_valid, 0);
    chk("flush_res", mem_result, 0);
    chk("flush_addr", mem_addr, 0);
    chk("flush_flags", flags, 3'b111);
    flush = 1'b0;

    // Invalid EX with flag-setting opcode
    drive(1'b0, 4'b0000, 16'h7777, 16'h8888, 3'b000);
    step();
    chk("inv_flags", flags, 3'b111);
    chk("inv_valid", mem_valid, 0);

    // Branch sweep
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 4'b0000, 16'h0, 16'(f), 3'(f));
      br_cond = 3'b000;
      step();
      chk("sweep_flags", flags, 32'(f));
      for (int c = 0; c < 8; c++) begin
        br_cond = 3'(c);
        #1;
        chk($sformatf("br_f%0d_c%0d", f, c), br_taken, ref_br(3'(f), 3'(c)));
      end
    end
    // flags now 3'b111

    // Flush with HLT in EX
    flush = 1'b1;
    drive(1'b1, 4'b1111, 16'h0, 16'h0, 3'b000);
    step();
    chk("flush_hlt_halted", halted, 0);
    chk("flush_hlt_mhalt", mem_halt, 0);
    flush = 1'b0;

    // HLT capture
    drive(1'b1, 4'b1111, 16'h0ABC, 16'h0DEF, 3'b000);
    step();
    chk("hlt_mhalt", mem_halt, 1);
    chk("hlt_halted", halted, 1);
    chk("hlt_valid", mem_valid, 1);
    drive(1'b1, 4'b0000, 16'h1111, 16'h2222, 3'b010);
    step();
    chk("post_hlt_valid", mem_valid, 0);
    chk("post_hlt_flags", flags, 3'b111);
    chk("post_hlt_halted", halted, 1);

    // Asynchronous reset mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("async_halted", halted, 0);
    chk("async_flags", flags, 0);
    chk("async_mhalt", mem_halt, 0);
    rst = 1'b0;

    // First capture after deassertion
    drive(1'b1, 4'b0000, 16'h0001, 16'h0002, 3'b100);
    step();
    chk("after_rst_flags", flags, 3'b100);
    chk("after_rst_valid", mem_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
